// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
//   state_t   : serialiser FSM states (PARITY only with UART_TX_PARITY_EN)
//   PAR_*     : parity_mode encodings (00 none, 01 even, 10 odd, 11 none)
//   calc_inc  : baud accumulator increment, round(baud*2^acc_width/clk_freq)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  function automatic longint unsigned calc_inc(input longint unsigned clk_freq,
                                               input longint unsigned baud,
                                               input int unsigned     acc_width);
    return ((baud << acc_width) + clk_freq / 2) / clk_freq;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional baud generator: an ACC_WIDTH-bit phase accumulator whose carry
// out is the bit tick.
//   clk, rst : clock, synchronous active-high reset
//   en       : advance the accumulator this cycle
//   clr      : force the accumulator to zero (priority over en)
//   tick     : carry bit of the accumulator, one cycle per bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned ACC_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [ACC_WIDTH:0] INC = (ACC_WIDTH + 1)'(calc_inc(CLK_FREQ, BAUD, ACC_WIDTH));

  logic [ACC_WIDTH:0] acc;

  // The carry is dropped on every add, so it is high for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= {1'b0, acc[ACC_WIDTH-1:0]} + INC;
    end
  end

  assign tick = acc[ACC_WIDTH];

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised RS-232 transmitter: byte FIFO feeding a start/data/[parity]/stop
// serialiser clocked by a fractional baud accumulator. Back-to-back characters
// leave no idle gap on the line.
// Build option: UART_TX_PARITY_EN adds the parity bit selected by parity_mode;
// without it parity_mode is ignored.
//   clk, rst    : clock, synchronous active-high reset
//   in_data     : character, only [DATA_BITS-1:0] sent, LSB first
//   in_valid    : producer has a character
//   in_ready    : FIFO can accept; transfer on in_valid & in_ready
//   parity_mode : 00 none, 01 even, 10 odd, 11 none (latched per frame)
//   txd         : registered serial line, idle high
//   busy        : frame in progress or FIFO non-empty
//   fifo_count  : FIFO occupancy
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    parity_mode,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  assign in_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = in_valid & in_ready;
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data[DATA_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upper character bits and (without parity) parity_mode are deliberately unused.
  logic unused_inputs;
  assign unused_inputs = ^{in_data, parity_mode};

  // ---------------------------------------------------------------- baud
  state_t state;
  state_t state_nx;
  logic   tick;
  logic   baud_clr;

  // Cleared by the next state rather than the current one so that the pop
  // cycle already counts towards the start bit: every bit, including the
  // first, then spans exactly one tick period.
  assign baud_clr = (state_nx == ST_IDLE);

  uart_baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (~baud_clr),
    .clr  (baud_clr),
    .tick (tick)
  );

  // ---------------------------------------------------------------- FSM
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_cnt;
  logic [1:0]           stop_cnt;
  logic                 tx_line;
`ifdef UART_TX_PARITY_EN
  logic                 par_en;
  logic                 par_bit;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    tx_line  = 1'b1;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        tx_line = 1'b0;
        if (tick) state_nx = ST_DATA;
      end
      ST_DATA: begin
        tx_line = shreg[0];
        if (tick && (bit_cnt == 4'(DATA_BITS - 1))) begin
`ifdef UART_TX_PARITY_EN
          state_nx = par_en ? ST_PARITY : ST_STOP;
`else
          state_nx = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_line = par_bit;
        if (tick) state_nx = ST_STOP;
      end
`endif
      ST_STOP: begin
        tx_line = 1'b1;
        if (tick && (stop_cnt == 2'(STOP_BITS - 1))) begin
          if (count != '0) begin
            pop      = 1'b1;
            state_nx = ST_START;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txd      <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
`endif
    end else begin
      txd <= tx_line;
      if (pop) begin
        shreg    <= head;
        bit_cnt  <= '0;
        stop_cnt <= '0;
`ifdef UART_TX_PARITY_EN
        par_en   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
        par_bit  <= (parity_mode == PAR_EVEN) ? ^head : ~^head;
`endif
      end else if (tick) begin
        if (state == ST_DATA) begin
          shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (state == ST_STOP) begin
          stop_cnt <= stop_cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (state != ST_IDLE) | (count != '0);

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: three instances (8N1 at 16 clk/bit,
// 7 data + 2 stop at 16 clk/bit, 8N1 at 50 MHz / 115200).
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // instance A: 8N1, 16 clk/bit, depth 4
  logic       rst_a = 1'b1, in_valid_a = 1'b0, in_ready_a, txd_a, busy_a;
  logic [8:0] in_data_a = '0;
  logic [1:0] parity_mode_a = 2'b00;
  logic [2:0] fifo_count_a;
  // instance B: 7 data, 2 stop, 16 clk/bit
  logic       rst_b = 1'b1, in_valid_b = 1'b0, in_ready_b, txd_b, busy_b;
  logic [8:0] in_data_b = '0;
  logic [1:0] parity_mode_b = 2'b00;
  logic [2:0] fifo_count_b;
  // instance C: 8N1, 50 MHz / 115200
  logic       rst_c = 1'b1, in_valid_c = 1'b0, in_ready_c, txd_c, busy_c;
  logic [8:0] in_data_c = '0;
  logic [1:0] parity_mode_c = 2'b00;
  logic [2:0] fifo_count_c;

  uart_tx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .ACC_WIDTH(16),
                  .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst_a), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .parity_mode(parity_mode_a), .txd(txd_a),
    .busy(busy_a), .fifo_count(fifo_count_a));

  uart_tx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .ACC_WIDTH(16),
                  .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .parity_mode(parity_mode_b), .txd(txd_b),
    .busy(busy_b), .fifo_count(fifo_count_b));

  uart_tx_param #(.CLK_FREQ(50_000_000), .BAUD(115_200), .ACC_WIDTH(16),
                  .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst_c), .in_data(in_data_c), .in_valid(in_valid_c),
    .in_ready(in_ready_c), .parity_mode(parity_mode_c), .txd(txd_c),
    .busy(busy_c), .fifo_count(fifo_count_c));

  int   sel = 0;
  logic txd_mon, busy_mon;
  always_comb begin
    txd_mon  = txd_a;
    busy_mon = busy_a;
    if (sel == 1) begin
      txd_mon  = txd_b;
      busy_mon = busy_b;
    end else if (sel == 2) begin
      txd_mon  = txd_c;
      busy_mon = busy_c;
    end
  end

  int   run_len [16];
  logic run_lvl [16];

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [8:0] d, output int c0);
    in_data_a = d; in_valid_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0; c0 = cyc;
  endtask

  task automatic push_b(input logic [8:0] d, output int c0);
    in_data_b = d; in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0; c0 = cyc;
  endtask

  task automatic push_c(input logic [8:0] d, output int c0);
    in_data_c = d; in_valid_c = 1'b1;
    @(negedge clk);
    in_valid_c = 1'b0; c0 = cyc;
  endtask

  // Advance to the first negedge with the selected line low.
  task automatic wait_fall(input string tag, input int limit);
    int n = 0;
    while (txd_mon !== 1'b0 && n < limit) begin
      @(negedge clk); n++;
    end
    check({tag, "_fall"}, txd_mon, 0);
  endtask

  task automatic wait_busy_low(input string tag, input int limit, output int t, output int lows);
    int n = 0;
    lows = 0;
    while (busy_mon !== 1'b0 && n < limit) begin
      @(negedge clk); n++;
      if (txd_mon === 1'b0) lows++;
    end
    check({tag, "_busy_low"}, busy_mon, 0);
    t = cyc;
  endtask

  // Called at the first low sample; records n complete level runs.
  task automatic capture_runs(input int n, input int limit);
    logic cur;
    int   len, k, guard;
    for (int i = 0; i < 16; i++) begin run_len[i] = 0; run_lvl[i] = 1'b1; end
    cur = txd_mon; len = 1; k = 0; guard = 0;
    while (k < n && guard < limit) begin
      @(negedge clk); guard++;
      if (txd_mon === cur) len++;
      else begin
        run_lvl[k] = cur; run_len[k] = len; k++;
        cur = txd_mon; len = 1;
      end
    end
  endtask

  // Called at the first low sample; samples each bit at its centre.
  task automatic rx_frame(input string tag, input int period, input int nd,
                          input bit has_par, input logic par_exp, input int ns,
                          input logic [8:0] data_exp);
    logic [8:0] d = '0;
    repeat (period / 2) @(negedge clk);
    check({tag, "_start"}, txd_mon, 0);
    for (int i = 0; i < nd; i++) begin
      repeat (period) @(negedge clk);
      d[i] = txd_mon;
    end
    check({tag, "_data"}, d, data_exp);
    if (has_par) begin
      repeat (period) @(negedge clk);
      check({tag, "_parity"}, txd_mon, par_exp);
    end
    for (int j = 0; j < ns; j++) begin
      repeat (period) @(negedge clk);
      check({tag, "_stop"}, txd_mon, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c0, t, lows, accepted, t0, tf;
    logic       rdy;
    logic [8:0] ch [6];
    ch = '{9'h0F0, 9'h1A5, 9'h03C, 9'h0C3, 9'h15A, 9'h0FF};

    // ---- reset state
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    check("rst_txd_a", txd_a, 1);       check("rst_busy_a", busy_a, 0);
    check("rst_ready_a", in_ready_a, 1); check("rst_count_a", fifo_count_a, 0);
    check("rst_txd_b", txd_b, 1);       check("rst_busy_b", busy_b, 0);
    check("rst_txd_c", txd_c, 1);       check("rst_busy_c", busy_c, 0);
    repeat (2) @(negedge clk);

    // ---- 1: 8N1 0x55, every level run 16 cycles
    sel = 0;
    push_a(9'h055, c0);
    wait_fall("t1", 10);
    check("t1_latency", cyc - c0, 2);
    capture_runs(9, 400);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t1_run%0d_len", i), run_len[i], 16);
      check($sformatf("t1_run%0d_lvl", i), run_lvl[i], (i % 2 == 0) ? 0 : 1);
    end
    // FSM leaves IDLE one cycle after the push and holds the frame for 160 cycles
    wait_busy_low("t1", 400, t, lows);
    check("t1_frame_len", t - c0 - 1, 160);
    repeat (4) @(negedge clk);

    // ---- 2: six pushes with valid held, five accepted, contiguous frames
    fork
      begin
        in_valid_a = 1'b1; in_data_a = ch[0]; accepted = 0;
        for (int i = 0; i < 12; i++) begin
          rdy = in_ready_a;
          @(negedge clk);
          if (rdy) begin
            accepted++;
            if (accepted < 6) in_data_a = ch[accepted];
          end
        end
        check("t2_accepted", accepted, 5);
        check("t2_ready_full", in_ready_a, 0);
        check("t2_count_full", fifo_count_a, 4);
        in_valid_a = 1'b0;
      end
      begin
        t0 = 0;
        for (int k = 0; k < 5; k++) begin
          wait_fall($sformatf("t2_f%0d", k), 400);
          tf = cyc;
          if (k == 0) t0 = tf;
          check($sformatf("t2_f%0d_offset", k), tf - t0, 160 * k);
          rx_frame($sformatf("t2_f%0d", k), 16, 8, 1'b0, 1'b0, 1, {1'b0, ch[k][7:0]});
        end
      end
    join
    wait_busy_low("t2", 400, t, lows);
    check("t2_count_empty", fifo_count_a, 0);
    repeat (4) @(negedge clk);

    // ---- 3: parity
`ifdef UART_TX_PARITY_EN
    parity_mode_a = 2'b10;
    push_a(9'h007, c0);
    wait_fall("t3_odd", 10);
    parity_mode_a = 2'b01;  // mid-frame change must not affect this frame
    rx_frame("t3_odd", 16, 8, 1'b1, 1'b0, 1, 9'h007);
    wait_busy_low("t3_odd", 400, t, lows);
    check("t3_odd_len", t - c0 - 1, 176);
    parity_mode_a = 2'b01;
    push_a(9'h007, c0);
    wait_fall("t3_even", 10);
    rx_frame("t3_even", 16, 8, 1'b1, 1'b1, 1, 9'h007);
    wait_busy_low("t3_even", 400, t, lows);
    check("t3_even_len", t - c0 - 1, 176);
    parity_mode_a = 2'b11;
    push_a(9'h007, c0);
    wait_fall("t3_m11", 10);
    rx_frame("t3_m11", 16, 8, 1'b0, 1'b0, 1, 9'h007);
    wait_busy_low("t3_m11", 400, t, lows);
    check("t3_m11_len", t - c0 - 1, 160);
`else
    parity_mode_a = 2'b10;
    push_a(9'h007, c0);
    wait_fall("t3_ign", 10);
    rx_frame("t3_ign", 16, 8, 1'b0, 1'b0, 1, 9'h007);
    wait_busy_low("t3_ign", 400, t, lows);
    check("t3_ign_len", t - c0 - 1, 160);
`endif
    parity_mode_a = 2'b00;
    repeat (4) @(negedge clk);

    // ---- 4: 7 data + 2 stop, 0x1FF
    sel = 1;
    push_b(9'h1FF, c0);
    wait_fall("t4", 10);
    capture_runs(1, 100);
    check("t4_start_len", run_len[0], 16);
    wait_busy_low("t4", 400, t, lows);
    check("t4_no_low_after_start", lows, 0);
    check("t4_frame_len", t - c0 - 1, 160);
    repeat (4) @(negedge clk);

    // ---- 5: reset during data bit 3
    sel = 0;
    push_a(9'h000, c0);
    push_a(9'h000, t);
    push_a(9'h000, t);
    wait_fall("t5", 10);
    repeat (72) @(negedge clk);
    check("t5_mid_frame", txd_a, 0);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("t5_txd", txd_a, 1);
    check("t5_busy", busy_a, 0);
    check("t5_count", fifo_count_a, 0);
    check("t5_ready", in_ready_a, 1);
    repeat (40) @(negedge clk);
    check("t5_txd_idle", txd_a, 1);
    check("t5_busy_idle", busy_a, 0);

    // ---- 6: 50 MHz / 115200, fractional bit timing
    sel = 2;
    push_c(9'h055, c0);
    wait_fall("t6", 10);
    capture_runs(9, 6000);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t6_run%0d_len_ok", i), (run_len[i] == 434 || run_len[i] == 435), 1);
      check($sformatf("t6_run%0d_lvl", i), run_lvl[i], (i % 2 == 0) ? 0 : 1);
    end
    wait_busy_low("t6", 6000, t, lows);
    check("t6_frame_len_ok", ((t - c0 - 1) >= 4338 && (t - c0 - 1) <= 4342), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
